// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: decodes RV32 load/store requests,
// drives a synchronous word-wide SRAM and returns one extended response per request.
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_func3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_reg, state_next;
    logic           we_reg;
    logic [2:0]     func3_reg;
    logic [AW+1:0]  addr_reg;
    logic [31:0]    wdata_reg;
    logic           err_reg;
    logic [31:0]    rdata_reg;
    logic [CW-1:0]  cnt_reg;

    logic           accept;
    logic           code_ok;
    logic           misaligned;
    logic           out_of_range;
    logic           req_err;

    assign accept = req_valid && (state_reg == IDLE);

    // Request legality is decided from the live inputs at the accept edge.
    always_comb begin
        code_ok      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        if (req_we) begin
            code_ok = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010);
        end else begin
            code_ok = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010) ||
                      (req_func3 == 3'b100) || (req_func3 == 3'b101);
        end
        case (req_func3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_err = !code_ok || misaligned || out_of_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = req_err ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == WAIT_LAST) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    always_comb begin
        ld_byte  = sram_rdata[{addr_reg[1:0], 3'b000} +: 8];
        ld_half  = sram_rdata[{addr_reg[1], 4'b0000} +: 16];
        case (func3_reg)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_value = sram_rdata;
            3'b100:  ld_value = {24'h0, ld_byte};
            3'b101:  ld_value = {16'h0, ld_half};
            default: ld_value = 32'h0;
        endcase
    end

    // SRAM data is valid during the first WAIT cycle; the wait count keeps running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg    <= 1'b0;
            func3_reg <= 3'b000;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
            err_reg   <= 1'b0;
            rdata_reg <= 32'h0;
            cnt_reg   <= '0;
        end else begin
            if (accept) begin
                we_reg    <= req_we;
                func3_reg <= req_func3;
                addr_reg  <= req_addr[AW+1:0];
                wdata_reg <= req_wdata;
                err_reg   <= req_err;
                rdata_reg <= 32'h0;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == '0 && !we_reg) begin
                    rdata_reg <= ld_value;
                end
            end
        end
    end

    always_comb begin
        req_ready  = (state_reg == IDLE);
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = 32'h0;
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        case (state_reg)
            ISSUE: begin
                sram_en   = 1'b1;
                sram_addr = addr_reg[AW+1:2];
                if (we_reg) begin
                    case (func3_reg[1:0])
                        2'b00: begin
                            sram_we    = 4'b0001 << addr_reg[1:0];
                            sram_wdata = {4{wdata_reg[7:0]}};
                        end
                        2'b01: begin
                            sram_we    = 4'b0011 << addr_reg[1:0];
                            sram_wdata = {2{wdata_reg[15:0]}};
                        end
                        default: begin
                            sram_we    = 4'b1111;
                            sram_wdata = wdata_reg;
                        end
                    endcase
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_reg;
                rsp_rdata = err_reg ? 32'h0 : rdata_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (WAIT_CYCLES 0 and 3), each with an
// SRAM model, checked against a byte-addressed reference memory with RV32 load/store rules.
module tb_dmem_responder;

    localparam int DW = 64;
    localparam int AW = $clog2(DW);
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req_valid  [2];
    logic          req_we     [2];
    logic [2:0]    req_func3  [2];
    logic [31:0]   req_addr   [2];
    logic [31:0]   req_wdata  [2];
    logic          req_ready  [2];
    logic          rsp_valid  [2];
    logic [31:0]   rsp_rdata  [2];
    logic          rsp_err    [2];
    logic          sram_en    [2];
    logic [3:0]    sram_we    [2];
    logic [AW-1:0] sram_addr  [2];
    logic [31:0]   sram_wdata [2];

    logic [7:0] ref_mem [2][4*DW];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] init_word(input int g, input int i);
        return (32'(i) * 32'h9E3779B1) ^ (32'(g) << 24) ^ 32'h5A5A_A5A5;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] mem [DW];
        logic [31:0] rdata;
        initial for (int i = 0; i < DW; i++) mem[i] = init_word(gi, i);
        always @(posedge clk) begin
            if (sram_en[gi]) begin
                rdata <= mem[sram_addr[gi]];
                for (int b = 0; b < 4; b++)
                    if (sram_we[gi][b]) mem[sram_addr[gi]][8*b +: 8] <= sram_wdata[gi][8*b +: 8];
            end
        end
        dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(gi == 0 ? 0 : W1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[gi]),
            .req_we     (req_we[gi]),
            .req_func3  (req_func3[gi]),
            .req_addr   (req_addr[gi]),
            .req_wdata  (req_wdata[gi]),
            .req_ready  (req_ready[gi]),
            .rsp_valid  (rsp_valid[gi]),
            .rsp_rdata  (rsp_rdata[gi]),
            .rsp_err    (rsp_err[gi]),
            .sram_en    (sram_en[gi]),
            .sram_we    (sram_we[gi]),
            .sram_addr  (sram_addr[gi]),
            .sram_wdata (sram_wdata[gi]),
            .sram_rdata (rdata)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: size from func3, legality table, alignment by modulo, little-endian bytes.
    function automatic void exp_resp(input int d, input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rd,
                                     output logic [3:0] mask, output logic [31:0] wd);
        int n;
        bit legal;
        logic [31:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !legal || (addr % n != 0) || (addr / 4 >= DW);
        rd = 32'h0; mask = 4'h0; wd = 32'h0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < 4; k++) wd[8*k +: 8] = wdata[8*(k % n) +: 8];
                for (int k = 0; k < n; k++) begin
                    ref_mem[d][addr + k] = wdata[8*k +: 8];
                    mask[(addr % 4) + k] = 1'b1;
                end
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[d][addr + k];
                if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endfunction

    // Starts at a negedge, returns at the negedge after the response cycle.
    task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er);
        logic e_err;
        logic [31:0] e_rd, e_wd, wd_seen;
        logic [3:0] e_mask, we_seen;
        logic [AW-1:0] ad_seen;
        int n, en_cnt, e_lat;
        bit got, ready_bad, stray;
        exp_resp(d, we, f3, addr, wdata, e_err, e_rd, e_mask, e_wd);
        e_lat = e_err ? 0 : 2 + ((d == 0) ? 0 : W1);
        rd = 32'h0; er = 1'b0; n = 0; en_cnt = 0; got = 0; ready_bad = 0; stray = 0;
        we_seen = 4'h0; wd_seen = 32'h0; ad_seen = '0;
        check_eq("ready_idle", 32'(req_ready[d]), 1);
        req_valid[d] = 1'b1; req_we[d] = we; req_func3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_func3[d] = 3'($urandom);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
        while (!got && n < 40) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                got = 1; rd = rsp_rdata[d]; er = rsp_err[d];
            end else begin
                if (sram_en[d]) begin
                    en_cnt++; we_seen = sram_we[d]; wd_seen = sram_wdata[d]; ad_seen = sram_addr[d];
                end else if (sram_we[d] != 4'h0 || sram_wdata[d] != 32'h0) begin
                    stray = 1;
                end
                if (req_ready[d]) ready_bad = 1;
                n++;
            end
        end
        check_eq("resp_timeout", 32'(got), 1);
        if (got) begin
            check_eq("latency", n, e_lat);
            check_eq("rsp_err", 32'(er), 32'(e_err));
            check_eq("rsp_rdata", rd, e_rd);
            check_eq("sram_en_cnt", en_cnt, e_err ? 0 : 1);
            check_eq("ready_busy", 32'(ready_bad), 0);
            check_eq("sram_idle_zero", 32'(stray), 0);
            if (!e_err) begin
                check_eq("sram_addr", 32'(ad_seen), addr >> 2);
                check_eq("sram_we", 32'(we_seen), 32'(e_mask));
                check_eq("sram_wdata", wd_seen, e_wd);
            end
        end
        @(negedge clk);
        check_eq("post_valid", {rsp_valid[d], rsp_err[d]}, 0);
        check_eq("post_rdata", rsp_rdata[d], 0);
        check_eq("post_ready", 32'(req_ready[d]), 1);
        $display("[TB] dut%0d %s f3=%0d addr=%08h wdata=%08h -> err=%0b rdata=%08h lat=%0d",
                 d, we ? "ST" : "LD", f3, addr, wdata, er, rd, n);
    endtask

    // Accept a request, then pull reset after cyc further edges; the request must vanish.
    task automatic abort_req(input int d, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata, input int cyc);
        req_valid[d] = 1'b1; req_we[d] = we; req_func3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        repeat (cyc) @(posedge clk);
        if (cyc > 0) #1;
        check_eq("busy_pre_rst", 32'(req_ready[d]), 0);
        if (we) check_eq("we_live", 32'(sram_we[d] != 4'h0), 1);
        rst_n = 1'b0; #1;
        check_eq("rst_sram_we", 32'(sram_we[d]), 0);
        check_eq("rst_sram_en", 32'(sram_en[d]), 0);
        check_eq("rst_sram_wdata", sram_wdata[d], 0);
        check_eq("rst_ready", 32'(req_ready[d]), 1);
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_rsp", {rsp_valid[d], rsp_err[d]}, 0);
            check_eq("rst_ready_hold", 32'(req_ready[d]), 1);
        end
        rst_n = 1'b1;
        $display("[TB] dut%0d %s f3=%0d addr=%08h aborted by reset after %0d cycles",
                 d, we ? "ST" : "LD", f3, addr, cyc);
    endtask

    initial begin
        logic [31:0] rd, w;
        logic er;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_func3[d] = 3'h0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
            for (int i = 0; i < DW; i++) begin
                w = init_word(d, i);
                for (int b = 0; b < 4; b++) ref_mem[d][4*i + b] = w[8*b +: 8];
            end
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_ready", 32'(req_ready[d]), 1);
            check_eq("reset_rsp", {rsp_valid[d], rsp_err[d], sram_en[d], sram_we[d]}, 0);
            check_eq("reset_data", rsp_rdata[d] | sram_wdata[d] | 32'(sram_addr[d]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, rd, er);
        check_eq("sw_ack_err", 32'(er), 0);
        do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
        check_eq("lw_deadbeef", rd, 32'hDEAD_BEEF);
        do_req(0, 1'b1, 3'd0, 32'h13, 32'h0000_0080, rd, er);
        do_req(0, 1'b0, 3'd0, 32'h13, 32'h0, rd, er);
        check_eq("lb_sign", rd, 32'hFFFF_FF80);
        do_req(0, 1'b0, 3'd4, 32'h13, 32'h0, rd, er);
        check_eq("lbu_zero", rd, 32'h0000_0080);
        do_req(0, 1'b0, 3'd1, 32'h11, 32'h0, rd, er);
        check_eq("lh_misalign", 32'(er), 1);
        do_req(0, 1'b1, 3'd2, 32'h02, 32'h1234_5678, rd, er);
        check_eq("sw_misalign", 32'(er), 1);
        do_req(0, 1'b0, 3'd3, 32'h00, 32'h0, rd, er);
        check_eq("ld_bad_code", 32'(er), 1);
        do_req(0, 1'b0, 3'd2, 32'(4 * DW), 32'h0, rd, er);
        check_eq("lw_range", 32'(er), 1);

        do_req(1, 1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, rd, er);
        do_req(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
        check_eq("lw_wait3", rd, 32'hCAFE_F00D);
        abort_req(1, 1'b0, 3'd2, 32'h20, 32'h0, 2);
        do_req(1, 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
        check_eq("lw_after_rst", rd, 32'hCAFE_F00D);
        abort_req(0, 1'b1, 3'd2, 32'h40, 32'h1111_1111, 0);
        do_req(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, er);

        for (int i = 0; i < 160; i++) begin
            int d;
            logic wr;
            logic [2:0] f;
            logic [31:0] a;
            d  = i % 2;
            wr = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 4 * DW + 7));
            do_req(d, wr, f, a, $urandom, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 32-bit words in the backing SRAM; power of two.
REQ-002 Parameter WAIT_CYCLES, default 0: extra wait states added after every SRAM access.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  the core presents a data-memory request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_func3  input  3  RV32 access width code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_ready  output  1  the responder can accept a request.
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  load result, already extended.
REQ-013 rsp_err  output  1  the request was rejected; qualified by rsp_valid.
REQ-014 sram_en  output  1  SRAM access enable.
REQ-015 sram_we  output  4  SRAM byte write enables.
REQ-016 sram_addr  output  log2(DEPTH_WORDS)  SRAM word index.
REQ-017 sram_wdata  output  32  lane-aligned write data.
REQ-018 sram_rdata  input  32  SRAM read data, valid one cycle after sram_en.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a clock edge.
REQ-021 On accept, the FSM SHALL latch req_we, req_func3, req_addr and req_wdata, and SHALL ignore all request inputs until it returns to IDLE.
REQ-022 Legal load codes SHALL be: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; every other load code is illegal.
REQ-023 Legal store codes SHALL be: 000 SB, 001 SH, 010 SW; every other store code is illegal.
REQ-024 A request SHALL be an error if any of these holds:
- the code is illegal;
- a halfword access has addr[0]=1;
- a word access has addr[1:0]≠00;
- addr[31:2] ≥ DEPTH_WORDS.
REQ-025 An error request SHALL go IDLE→RESP, assert rsp_err=1 with rsp_rdata=0, and SHALL never assert sram_en.
REQ-026 A legal request SHALL go IDLE→ISSUE. In ISSUE, sram_en=1 for exactly one cycle and sram_addr=addr[2+:log2(DEPTH_WORDS)].
REQ-027 Store lane mapping in ISSUE SHALL be:
- SB: sram_we=0001<<addr[1:0], wdata[7:0] replicated to all lanes;
- SH: sram_we=0011<<addr[1:0], wdata[15:0] replicated to both halves;
- SW: sram_we=1111.
REQ-028 For loads, sram_we SHALL be 0000.
REQ-029 From ISSUE the FSM SHALL go to WAIT. WAIT SHALL count WAIT_CYCLES additional cycles, so it lasts exactly WAIT_CYCLES+1 cycles, and then go to RESP.
REQ-030 A load SHALL capture sram_rdata on the edge after the ISSUE cycle; the count is not restarted by this capture.
REQ-031 In RESP, rsp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-032 Load data extraction SHALL be:
- select the byte or halfword at addr[1:0];
- LB/LH sign-extend to 32 bits;
- LBU/LHU zero-extend to 32 bits;
- LW passes the word unchanged.
REQ-033 A legal store SHALL respond with rsp_err=0 and rsp_rdata=0.
REQ-034 Latency from the accept edge T SHALL be:
- legal request: rsp_valid at cycle T+2+WAIT_CYCLES;
- error request: rsp_valid at cycle T+1.
REQ-035 Throughput SHALL be at most one request in flight; the next request can be accepted in the cycle after RESP.
REQ-036 rsp_rdata and rsp_err SHALL hold their values only while rsp_valid=1 and SHALL be 0 otherwise.
REQ-037 sram_en, sram_we and sram_wdata SHALL be 0 in every state except ISSUE.

Reset
REQ-038 While rst_n=0, the FSM SHALL be in IDLE and every output SHALL be 0, except req_ready, which SHALL be 1.
REQ-039 Reset asserted mid-transaction SHALL abort the transaction with no response.
REQ-040 If reset is asserted in a cycle where sram_we≠0, sram_we SHALL be forced to 0 immediately.
REQ-041 The first request accepted after reset release SHALL be handled normally.

Verification
REQ-042 SW to addr 0x10 with wdata 0xDEADBEEF, then LW from 0x10 (WAIT_CYCLES=0) → store ack with rsp_err=0; load rsp_valid 2 cycles after accept with rsp_rdata=0xDEADBEEF.
REQ-043 SB 0x80 to 0x13, then LB and LBU from 0x13 → sram_we=1000; LB returns 0xFFFFFF80; LBU returns 0x00000080.
REQ-044 LH from 0x11, SW to 0x02, and load with func3=011 → each gives rsp_err=1 one cycle after accept, and sram_en is never asserted.
REQ-045 WAIT_CYCLES=3, LW → rsp_valid exactly 5 cycles after accept, and req_ready=0 throughout.
REQ-046 Assert rst_n=0 during WAIT of a load → no rsp_valid; req_ready=1 while rst_n=0; a new LW after release completes correctly.
REQ-047 LW from 4*DEPTH_WORDS → rsp_err=1 and no SRAM access.
